// File: rtl/trans_pkg.sv
// ---------------------------------------------------------------------------
// trans_pkg
// Shared definitions for the transaction pipeline (deserializer, validator).
// Holds the 128-bit transaction word geometry, the field LSB positions, a
// packed struct view of the word and a small byte-extraction helper.
// No ports: package only.
// ---------------------------------------------------------------------------
package trans_pkg;

  localparam int TRANS_W         = 128;
  localparam int ID_W            = 48;
  localparam int AMOUNT_W        = 22;
  localparam int CASH_W          = 24;

  localparam int SENDER_LSB      = 80;
  localparam int RECEIVER_LSB    = 32;
  localparam int AMOUNT_LSB      = 10;
  localparam int BIT_BLOCK_START = 9;

  localparam int BYTES_PER_TRANS = TRANS_W / 8;
  localparam int BYTE_CNT_W      = $clog2(BYTES_PER_TRANS);

  // Field order matches the wire layout: sender in the top bits, reserved
  // bits at the bottom.
  typedef struct packed {
    logic [ID_W-1:0]     sender;
    logic [ID_W-1:0]     receiver;
    logic [AMOUNT_W-1:0] amount;
    logic                block_start;
    logic [8:0]          reserved;
  } trans_t;

  // Byte idx of a transaction word in transmission order (idx 0 = MSB byte).
  function automatic logic [7:0] trans_byte(input logic [TRANS_W-1:0] t,
                                            input int unsigned idx);
    return 8'(t >> (8 * (BYTES_PER_TRANS - 1 - idx)));
  endfunction

endpackage

// File: rtl/trans_deserializer_if.sv
// ---------------------------------------------------------------------------
// trans_deserializer_if
// Bundles the byte-side handshake and the transaction-side output of the
// deserializer.
//   byte_i / byte_valid_i / byte_ready_o : byte stream in, valid/ready
//   data_o / valid_o / ack_i             : head transaction, pop pulse
//   level_o                              : buffered transaction count
// master : the environment (byte source + validator)
// slave  : the deserializer
// ---------------------------------------------------------------------------
interface trans_deserializer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import trans_pkg::*;

  logic [7:0]                    byte_i;
  logic                          byte_valid_i;
  logic                          byte_ready_o;
  logic [TRANS_W-1:0]            data_o;
  logic                          valid_o;
  logic                          ack_i;
  logic [$clog2(FIFO_DEPTH):0]   level_o;

  modport master (
    output byte_i, byte_valid_i, ack_i,
    input  byte_ready_o, data_o, valid_o, level_o
  );

  modport slave (
    input  byte_i, byte_valid_i, ack_i,
    output byte_ready_o, data_o, valid_o, level_o
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a separate occupancy counter deciding full/empty,
// so pointers only need log2(DEPTH) bits and wrap naturally.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   head       : oldest entry, zero when empty
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
  // both pointers and leaves the count where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is forced to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trans_deserializer.sv
// ---------------------------------------------------------------------------
// trans_deserializer
// Assembles an MSB-first byte stream into 128-bit transaction words and
// buffers complete words in a FIFO for the validator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : trans_deserializer_if.slave
//              byte_i/byte_valid_i/byte_ready_o  byte handshake
//              data_o/valid_o                    head transaction
//              ack_i                             pop pulse
//              level_o                           buffered word count
// ---------------------------------------------------------------------------
module trans_deserializer
  import trans_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  trans_deserializer_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // The first 15 bytes are held here; element 0 is the MSB byte. The 16th
  // byte goes straight into the FIFO alongside them.
  logic [0:BYTES_PER_TRANS-2][7:0] asm_q;
  logic [BYTE_CNT_W-1:0]           byte_cnt;
  logic                            last_byte;
  logic                            ready;
  logic                            accept;
  logic                            push;
  logic [TRANS_W-1:0]              push_word;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [LVL_W-1:0]                fifo_count;
  logic [TRANS_W-1:0]              fifo_head;

  assign last_byte = (byte_cnt == BYTE_CNT_W'(BYTES_PER_TRANS - 1));
  // Only the final byte needs FIFO space; a same-cycle pop is not counted
  // so ready stays a function of registered state.
  assign ready     = !last_byte || !fifo_full;
  assign accept    = bus.byte_valid_i && ready;
  assign push      = accept && last_byte;
  assign push_word = {asm_q, bus.byte_i};

  // Assembly register and byte counter. The counter wraps from 15 to 0 on
  // the final byte, which is also the push edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      asm_q    <= '0;
    end else if (accept) begin
      if (!last_byte) asm_q[byte_cnt] <= bus.byte_i;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (TRANS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (bus.ack_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.byte_ready_o = ready;
  assign bus.data_o       = fifo_head;
  assign bus.valid_o      = !fifo_empty;
  assign bus.level_o      = fifo_count;

endmodule

// File: doc/trans_deserializer.md
# trans_deserializer

Front-end stage that assembles the incoming byte stream into 128-bit transaction words and feeds `trans_validator`. It buffers up to `FIFO_DEPTH` complete transactions. It presents the oldest one as `data_o`/`valid_o`, held stable until the validator's one-cycle `ack` pulse pops it. Byte-side flow control is a valid/ready handshake, so no transaction is ever dropped.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of buffered complete transactions; power of two, ≥2.

Ports:
- `clk`  in  1: sole clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `byte_i`  in  8: incoming transaction byte, MSB-first.
- `byte_valid_i`  in  1: `byte_i` is valid this cycle.
- `byte_ready_o`  out  1: block accepts a byte this cycle. A byte transfers on `byte_valid_i && byte_ready_o`.
- `data_o`  out  128: head transaction. Layout: `[127:80]` sender id, `[79:32]` receiver id, `[31:10]` amount, `[9]` block start, `[8:0]` reserved.
- `valid_o`  out  1: `data_o` holds a buffered transaction (FIFO not empty).
- `ack_i`  in  1: one-cycle pop pulse from the validator (its `ack_o`).
- `level_o`  out  `$clog2(FIFO_DEPTH)+1`: number of complete transactions buffered.

## Operation
- Assembly register is 128 bits, with byte counter `byte_cnt` in 0..15.
- Each accepted byte writes `asm[127-8*byte_cnt -: 8]`, then `byte_cnt` increments.
- Accepting byte 15 (the 16th byte) has these effects on the same edge:
  - pushes `{asm[127:8], byte_i}` into the FIFO;
  - returns `byte_cnt` to 0.
- `byte_ready_o = (byte_cnt != 15) || !full`.
  - Partial assembly continues while the FIFO is full; only the final byte stalls.
  - A pop in the same cycle does not grant space. `byte_ready_o` depends only on registered state, with no combinational path from `ack_i`.
- Output side:
  - `valid_o = !empty`.
  - `data_o = mem[rd_ptr]` when not empty, else 128'h0.
  - `data_o` is stable from the cycle `valid_o` rises until the edge that samples `ack_i`.
- `ack_i` while `valid_o` is high pops one entry. `ack_i` while empty is ignored: no pointer movement, no underflow.
- Push and pop on the same edge: both take effect, and `level_o` is unchanged.
- Pointers are `$clog2(FIFO_DEPTH)`-bit and wrap modulo `FIFO_DEPTH`. Full/empty is decided by a separate count register (`level_o`), saturating at 0 and `FIFO_DEPTH`.
- The block does not inspect field contents. Bit 9 and the amount pass through untouched.
- Reset (any time, including mid-assembly or with the FIFO full):
  - `byte_cnt=0`, pointers 0, `level_o=0`, `valid_o=0`, `data_o=0`;
  - `byte_ready_o=1` from the first cycle after reset;
  - the partially assembled word is discarded.

## Timing
- Byte-to-valid latency: with the FIFO empty, 16th byte accepted at edge N → `valid_o=1` and new `data_o` from just after edge N (1 cycle).
- Pop latency: `ack_i` sampled at edge M → next entry (or `valid_o=0`) visible just after edge M.
- Maximum throughput is one byte per cycle, i.e. one transaction per 16 cycles. The validator consumes slower, so the FIFO absorbs bursts.
- `byte_ready_o`, `valid_o`, `data_o` and `level_o` are functions of registered state only.
- `ack_i` is registered in the validator and arrives one cycle after it samples `valid_o`. `valid_o` therefore stays high for at least 2 cycles per transaction, which is legal.

## Structure
- Shared package `trans_pkg` holds:
  - `TRANS_W=128`, `ID_W=48`, `AMOUNT_W=22`, `CASH_W=24`;
  - field LSB constants (`SENDER_LSB=80`, `RECEIVER_LSB=32`, `AMOUNT_LSB=10`), `BIT_BLOCK_START=9`;
  - a packed `trans_t` struct.
- `trans_validator` switches to the package in the same change.
- Sub-module `sync_fifo` (parameters width, depth; ports push, pop, full, empty, count), instantiated with width `TRANS_W`. The deserializer top holds only the assembly register, byte counter and ready logic.

## Test plan
- Reset, then stream 16 bytes 0x00..0x0F with valid held → `data_o=128'h000102…0F`, `valid_o` rises the cycle after byte 0x0F, `level_o=1`.
- Send transaction A (sender 0x0000_0000_0001, receiver 0x0000_0000_0002, amount 50, bit9=1), then pulse `ack_i` 3 cycles later → `data_o` equals A's fields until the ack edge; then `valid_o=0`, `level_o=0`.
- Push 4 transactions with no ack, then send bytes of a 5th → bytes 0..14 accepted, `byte_ready_o=0` at byte 15. One `ack_i` → `byte_ready_o=1` the next cycle, 5th pushed, `level_o` returns to 4.
- Pulse `ack_i` while empty → `level_o` stays 0, a subsequent transaction appears intact with no phantom entry.
- With `level_o=2`, the 16th byte and `ack_i` arrive on the same edge → `level_o` stays 2 and `data_o` advances to the second entry.
- Assert `rst` after 7 bytes, then send a full fresh transaction → output equals the fresh 16 bytes exactly, with no residue from the aborted 7.
